// File: rtl/tt_harness_pkg.sv
// Shared types and constants for the TinyTapeout vector harness.
package tt_harness_pkg;
  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_DUT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  // Fibonacci taps 8,6,5,4 expressed as a bit mask over an 8-bit register
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
  localparam int          CYC_W        = 8;
endpackage

// File: rtl/tt_harness_misr.sv
// Galois MISR that folds one zero-extended sample per enabled cycle into the signature.
module tt_harness_misr #(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);
  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr)
      sig_d = '0;
    else if (en)
      sig_d = (sig_q << 1) ^ (sig_q[SIG_W-1] ? SIG_POLY : '0) ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;
endmodule

// File: rtl/tt_vector_harness.sv
// Stimulus/response harness: resets a tt_um_* DUT, plays a vector sequence, MISR-compresses uo_out.
// Define HARNESS_UIO_EN to drive/sample the bidirectional uio bus as well.
module tt_vector_harness
  import tt_harness_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 16,
  parameter int                SIG_W     = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY  = SIG_W'(DEF_SIG_POLY),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(8'h01),
  parameter int                RST_CYC   = 4,
  parameter int                LAT       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [DATA_W-1:0] const_pat,
  output logic [DATA_W-1:0] dut_ui,
  input  logic [DATA_W-1:0] dut_uo,
  output logic              dut_ena,
  output logic              dut_rst_n,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_cnt
`ifdef HARNESS_UIO_EN
  ,
  output logic [DATA_W-1:0] dut_uio_in,
  input  logic [DATA_W-1:0] dut_uio_out,
  input  logic [DATA_W-1:0] dut_uio_oe
`endif
);
  localparam logic [DATA_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [DATA_W-1:0] gen_q, gen_d, gen_load, gen_next;
  logic [DATA_W-1:0] dut_ui_q, dut_ui_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [LAT-1:0]    vld_pipe_q, vld_pipe_d;
  logic              misr_clr;
  logic [DATA_W-1:0] sample;

  always_comb begin
    gen_load = const_pat;
    case (mode_e'(mode))
      MODE_LFSR: gen_load = SEED_EFF;
      MODE_WALK: gen_load = DATA_W'(1);
      default:   gen_load = const_pat;
    endcase
  end

  always_comb begin
    gen_next = gen_q;
    case (mode_q)
      MODE_COUNT: gen_next = gen_q + DATA_W'(1);
      MODE_LFSR:  gen_next = {gen_q[DATA_W-2:0], ^(gen_q & DATA_W'(LFSR_TAPS))};
      MODE_WALK:  gen_next = {gen_q[DATA_W-2:0], gen_q[DATA_W-1]};
      default:    gen_next = gen_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    gen_d     = gen_q;
    dut_ui_d  = dut_ui_q;
    vec_cnt_d = vec_cnt_q;
    cyc_d     = cyc_q;
    misr_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dut_ui_d = '0;
        if (start) begin
          state_d   = ST_RESET_DUT;
          mode_d    = mode_e'(mode);
          num_d     = num_vec;
          gen_d     = gen_load;
          vec_cnt_d = '0;
          cyc_d     = '0;
          misr_clr  = 1'b1;
        end
      end
      ST_RESET_DUT: begin
        cyc_d = cyc_q + CYC_W'(1);
        // An empty run spends one extra cycle here so done lands at RST_CYC+1
        if (num_q == '0) begin
          if (cyc_q == CYC_W'(RST_CYC)) state_d = ST_DONE;
        end else if (cyc_q == CYC_W'(RST_CYC - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        dut_ui_d  = gen_q;
        gen_d     = gen_next;
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
        if (vec_cnt_q == num_q - CNT_W'(1)) begin
          state_d = ST_DRAIN;
          cyc_d   = '0;
        end
      end
      ST_DRAIN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == CYC_W'(LAT - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        dut_ui_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One valid bit per applied vector, aged LAT cycles before its response is sampled
  assign vld_pipe_d = (vld_pipe_q << 1) | LAT'(state_q == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_COUNT;
      num_q      <= '0;
      gen_q      <= '0;
      dut_ui_q   <= '0;
      vec_cnt_q  <= '0;
      cyc_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      num_q      <= num_d;
      gen_q      <= gen_d;
      dut_ui_q   <= dut_ui_d;
      vec_cnt_q  <= vec_cnt_d;
      cyc_q      <= cyc_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

`ifdef HARNESS_UIO_EN
  assign dut_uio_in = ~dut_ui_q;
  assign sample     = dut_uo ^ (dut_uio_out & dut_uio_oe);
`else
  assign sample     = dut_uo;
`endif

  tt_harness_misr #(.SIG_W(SIG_W), .SIG_POLY(SIG_POLY)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (vld_pipe_q[LAT-1]),
    .din   (SIG_W'(sample)),
    .sig   (signature)
  );

  assign dut_ui    = dut_ui_q;
  assign vec_cnt   = vec_cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dut_ena   = (state_q == ST_RESET_DUT) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign dut_rst_n = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_DONE);
endmodule
